// File: rtl/ternary_dot_sequencer.sv
// ----------------------------------------------------------------------------
// ternary_dot_sequencer
//
// Purpose:
//   Sequences a 32-lane ternary dot product over CHUNKS chunks. Each chunk has
//   a positive and a negative weight bitplane and a binary activation word.
//   All three arrive little-endian over an 8-bit byte bus, 12 bytes per chunk.
//   One external PopCount32 is shared in time. The CNT_POS cycle adds
//   popcount(x & wpos). The CNT_NEG cycle subtracts popcount(x & wneg).
//   When the last chunk is done, the signed sum is held on result under a
//   valid/ready handshake.
//
// Optional feature (macro TERNARY_DOT_RELU_EN):
//   When defined, result presents max(acc, 0). The accumulator stays signed
//   in both builds, so only the output value is clamped.
//
// Ports:
//   clk          in   1   clock
//   rst_n        in   1   synchronous active-low reset
//   in_data      in   8   input byte
//   in_valid     in   1   in_data valid
//   in_ready     out  1   byte accepted this cycle (LOAD_* states only)
//   pop_data     out  32  operand to the shared PopCount32
//   pop_count    in   6   combinational popcount of pop_data
//   result       out  16  signed dot product, sign-extended from ACC_W
//   result_valid out  1   result available
//   result_ready in   1   consumer takes result
//   busy         out  1   a dot product is in progress
// ----------------------------------------------------------------------------
module ternary_dot_sequencer #(
  parameter int CHUNKS = 4,
  parameter int ACC_W  = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] pop_data,
  input  logic [5:0]  pop_count,
  output logic [15:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy
);

  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [2:0] {
    LOAD_POS,
    LOAD_NEG,
    LOAD_X,
    CNT_POS,
    CNT_NEG,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]            chunk_cnt_q, chunk_cnt_d;
  logic [31:0]              wpos_q, wpos_d;
  logic [31:0]              wneg_q, wneg_d;
  logic [31:0]              x_q, x_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [15:0]              result_q, result_d;
  logic                     result_valid_q, result_valid_d;

  // Popcount is unsigned (0..32), so zero-extend it before the signed add.
  logic signed [ACC_W-1:0]  pop_ext;
  assign pop_ext = $signed({{(ACC_W-6){1'b0}}, pop_count});

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    chunk_cnt_d    = chunk_cnt_q;
    wpos_d         = wpos_q;
    wneg_d         = wneg_q;
    x_d            = x_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    in_ready       = 1'b0;
    pop_data       = '0;

    unique case (state_q)
      LOAD_POS, LOAD_NEG, LOAD_X: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // The byte counter selects the byte lane, so byte 0 lands in [7:0].
          unique case (state_q)
            LOAD_POS: wpos_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
            LOAD_NEG: wneg_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
            default:  x_d[{byte_cnt_q, 3'b000} +: 8]    = in_data;
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            unique case (state_q)
              LOAD_POS: state_d = LOAD_NEG;
              LOAD_NEG: state_d = LOAD_X;
              default:  state_d = CNT_POS;
            endcase
          end
        end
      end
      CNT_POS: begin
        pop_data = x_q & wpos_q;
        acc_d    = acc_q + pop_ext;
        state_d  = CNT_NEG;
      end
      CNT_NEG: begin
        pop_data = x_q & wneg_q;
        acc_d    = acc_q - pop_ext;
        if (chunk_cnt_q == CW'(CHUNKS - 1)) begin
          state_d        = DONE;
          result_valid_d = 1'b1;
          // The final sum is registered together with result_valid, so both
          // reach the output in the same cycle.
`ifdef TERNARY_DOT_RELU_EN
          result_d = acc_d[ACC_W-1] ? 16'h0000 : 16'(acc_d);
`else
          result_d = 16'(acc_d);
`endif
        end else begin
          state_d     = LOAD_POS;
          chunk_cnt_d = chunk_cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d        = LOAD_POS;
          acc_d          = '0;
          chunk_cnt_d    = '0;
          result_valid_d = 1'b0;
        end
      end
      default: state_d = LOAD_POS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= LOAD_POS;
      byte_cnt_q     <= '0;
      chunk_cnt_q    <= '0;
      wpos_q         <= '0;
      wneg_q         <= '0;
      x_q            <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      chunk_cnt_q    <= chunk_cnt_d;
      wpos_q         <= wpos_d;
      wneg_q         <= wneg_d;
      x_q            <= x_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  // Idle means the first byte of a new dot product has not arrived yet.
  assign busy = !((state_q == LOAD_POS) && (byte_cnt_q == 2'd0) &&
                  (chunk_cnt_q == '0));

endmodule

// File: tb/tb_ternary_dot_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ternary_dot_sequencer
//
// Purpose:
//   Self-checking bench for ternary_dot_sequencer (CHUNKS=4). The expected
//   dot product is taken from per-chunk lane arrays using plain popcount
//   arithmetic. The shared PopCount32 is modelled with $countones. The bench
//   also checks the cycle-exact CNT_POS/CNT_NEG operands, the result latency,
//   backpressure, and the effect of a reset in the middle of a dot product.
// ----------------------------------------------------------------------------
module tb_ternary_dot_sequencer;

  localparam int CHUNKS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pop_data;
  logic [5:0]  pop_count;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  assign pop_count = 6'($countones(pop_data));

  ternary_dot_sequencer #(.CHUNKS(CHUNKS), .ACC_W(13)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pop_data     (pop_data),
    .pop_count    (pop_count),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;
  int dot_n  = 0;

  logic [31:0] wp_a [CHUNKS];
  logic [31:0] wn_a [CHUNKS];
  logic [31:0] x_a  [CHUNKS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Ternary dot product: each lane contributes +1 (wpos only), -1 (wneg only)
  // or 0 (neither set, or both set), and only when its activation bit is set.
  function automatic logic [15:0] ref_dot();
    int s;
    s = 0;
    for (int c = 0; c < CHUNKS; c++)
      s += $countones(x_a[c] & wp_a[c]) - $countones(x_a[c] & wn_a[c]);
`ifdef TERNARY_DOT_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        step();
      end
    end
    check("in_ready_load", {31'd0, in_ready}, 32'd1);
    check("pop_data_idle", pop_data, 32'd0);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic run_dot(input bit gaps, input int hold, input string name);
    logic [15:0] exp;
    exp = ref_dot();
    for (int c = 0; c < CHUNKS; c++) begin
      send_word(wp_a[c], gaps);
      send_word(wn_a[c], gaps);
      send_word(x_a[c], gaps);
      // First cycle after the 12th byte of the chunk: CNT_POS.
      check("cnt_pos_pop", pop_data, x_a[c] & wp_a[c]);
      check("cnt_in_ready", {31'd0, in_ready}, 32'd0);
      check("valid_early1", {31'd0, result_valid}, 32'd0);
      step();
      check("cnt_neg_pop", pop_data, x_a[c] & wn_a[c]);
      check("valid_early2", {31'd0, result_valid}, 32'd0);
      step();
    end
    // Third cycle after the final byte: result must be valid.
    check("result_valid", {31'd0, result_valid}, 32'd1);
    check("result", {16'd0, result}, {16'd0, exp});
    check("busy_done", {31'd0, busy}, 32'd1);
    check("pop_data_done", pop_data, 32'd0);
    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      step();
      check("hold_valid", {31'd0, result_valid}, 32'd1);
      check("hold_result", {16'd0, result}, {16'd0, exp});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("post_valid", {31'd0, result_valid}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_result_held", {16'd0, result}, {16'd0, exp});
    $display("dot %0d %s result %h expected %h", dot_n, name, result, exp);
    dot_n++;
  endtask

  task automatic fill(input logic [31:0] wp, input logic [31:0] wn, input logic [31:0] x);
    for (int c = 0; c < CHUNKS; c++) begin
      wp_a[c] = wp;
      wn_a[c] = wn;
      x_a[c]  = x;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
    check({tag, "_result"}, {16'd0, result}, 32'd0);
    check({tag, "_pop_data"}, pop_data, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // All lanes +1: 128.
    fill(32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF);
    run_dot(1'b0, 0, "all_pos");
    check("const_all_pos", {16'd0, result}, 32'h0000_0080);

    // Reset after 20 bytes of a random dot product.
    for (int c = 0; c < CHUNKS; c++) begin
      wp_a[c] = $urandom;
      wn_a[c] = $urandom;
      x_a[c]  = $urandom;
    end
    send_word(wp_a[0], 1'b0);
    send_word(wn_a[0], 1'b0);
    send_word(x_a[0], 1'b0);
    step();
    step();
    send_word(wp_a[1], 1'b0);
    send_word(wn_a[1], 1'b0);
    check("busy_midrun", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    fill(32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF);
    run_dot(1'b0, 0, "after_reset");
    check("const_after_reset", {16'd0, result}, 32'h0000_0080);

    // All lanes -1: -128, or 0 when clamped.
    fill(32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_dot(1'b0, 10, "all_neg");
`ifdef TERNARY_DOT_RELU_EN
    check("const_all_neg", {16'd0, result}, 32'h0000_0000);
`else
    check("const_all_neg", {16'd0, result}, 32'h0000_FF80);
`endif

    // Balanced halves cancel; then only chunk 2 keeps positive lanes.
    fill(32'h0000_FFFF, 32'hFFFF_0000, 32'h00FF_00FF);
    run_dot(1'b1, 0, "balanced");
    check("const_balanced", {16'd0, result}, 32'h0000_0000);
    x_a[2] = 32'h0000_FFFF;
    run_dot(1'b1, 3, "chunk2_pos");
    check("const_chunk2", {16'd0, result}, 32'h0000_0010);

    // Both planes set: every lane contributes 0.
    fill(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_dot(1'b0, 0, "both_set");
    check("const_both_set", {16'd0, result}, 32'h0000_0000);

    // Random ternary weights with input gaps and random backpressure.
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < CHUNKS; c++) begin
        wp_a[c] = $urandom;
        wn_a[c] = $urandom & ~(($urandom_range(0, 1) == 1) ? wp_a[c] : 32'd0);
        x_a[c]  = $urandom;
      end
      run_dot(1'b1, $urandom_range(0, 5), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends, even if a transfer stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout got %0d expected %0d", 0, 1);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
